// File: rtl/clock_ram_arbiter.sv
// Two-master round-robin arbiter for a single-port, byte-enabled on-chip RAM.
// Grants one transfer per cycle. A master may keep the port for at most
// BURST_MAX consecutive grants while the other master is waiting. Read data
// comes back one cycle after acceptance, tagged to its master by readdatavalid.
module clock_ram_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                hold,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic                m0_readdatavalid,
    output logic [DATA_W-1:0]   m0_readdata,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic                m1_readdatavalid,
    output logic [DATA_W-1:0]   m1_readdata,

    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(BURST_MAX);

    // Registered arbitration and read-return state.
    logic             last_owner_q, last_owner_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic             rvalid_q, rvalid_d;
    logic             rowner_q, rowner_d;

    logic req0, req1;
    logic grant_any, winner;
    logic grant0, grant1;
    logic win_read, win_write;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Pick this cycle's winner.
    // run_cnt_q == 0 only before the first grant after reset; in that case
    // the port goes to the master that is not last_owner, which makes m0 win
    // the first contention.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        grant_any = 1'b0;
        winner    = 1'b0;
        if (!hold) begin
            if (req0 && req1) begin
                grant_any = 1'b1;
                if (run_cnt_q != '0 && run_cnt_q < RUN_MAX) winner = last_owner_q;
                else                                        winner = ~last_owner_q;
            end else if (req0) begin
                grant_any = 1'b1;
                winner    = 1'b0;
            end else if (req1) begin
                grant_any = 1'b1;
                winner    = 1'b1;
            end
        end
    end

    assign grant0    = grant_any & ~winner;
    assign grant1    = grant_any & winner;
    assign win_read  = winner ? m1_read  : m0_read;
    assign win_write = winner ? m1_write : m0_write;

    // Drive the RAM port from the winner; quiet (all zero) when nobody is granted.
    always_comb begin
        ram_address    = '0;
        ram_byteenable = '0;
        ram_writedata  = '0;
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        if (grant_any) begin
            ram_chipselect = 1'b1;
            ram_write      = win_write;
            ram_address    = winner ? m1_address    : m0_address;
            ram_byteenable = winner ? m1_byteenable : m0_byteenable;
            ram_writedata  = winner ? m1_writedata  : m0_writedata;
        end
    end

    // Next-state: ownership run length and the read-return tag.
    // A read with write also set is a write and produces no readdatavalid.
    always_comb begin
        last_owner_d = last_owner_q;
        run_cnt_d    = run_cnt_q;
        rvalid_d     = grant_any & win_read & ~win_write;
        rowner_d     = winner;
        if (grant_any) begin
            if (winner == last_owner_q) begin
                if (run_cnt_q < RUN_MAX) run_cnt_d = run_cnt_q + CNT_W'(1);
            end else begin
                last_owner_d = winner;
                run_cnt_d    = CNT_W'(1);
            end
        end
    end

    // State registers; reset drops any read in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            last_owner_q <= 1'b1;
            run_cnt_q    <= '0;
            rvalid_q     <= 1'b0;
            rowner_q     <= 1'b0;
        end else begin
            last_owner_q <= last_owner_d;
            run_cnt_q    <= run_cnt_d;
            rvalid_q     <= rvalid_d;
            rowner_q     <= rowner_d;
        end
    end

    assign m0_waitrequest   = req0 & ~grant0;
    assign m1_waitrequest   = req1 & ~grant1;
    assign m0_readdatavalid = rvalid_q & (rowner_q == 1'b0);
    assign m1_readdatavalid = rvalid_q & (rowner_q == 1'b1);
    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;
    assign ram_clken        = 1'b1;

endmodule

// File: tb/tb_clock_ram_arbiter.sv
// Directed bench for clock_ram_arbiter. Two instances share the master-side
// stimulus: dut_a with BURST_MAX=2 and dut_b with BURST_MAX=1, each with its
// own behavioural 1024x32 byte-enabled RAM (1-cycle read latency).
// Inputs are driven just after the falling edge and sampled 1 ns later.
module tb_clock_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hold = 1'b0;
    logic [9:0]  m0_address = '0, m1_address = '0;
    logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
    logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [31:0] m0_writedata = '0, m1_writedata = '0;

    logic        a_m0_waitrequest, a_m0_readdatavalid, a_m1_waitrequest, a_m1_readdatavalid;
    logic [31:0] a_m0_readdata, a_m1_readdata, a_ram_writedata, a_ram_readdata;
    logic [9:0]  a_ram_address;
    logic [3:0]  a_ram_byteenable;
    logic        a_ram_chipselect, a_ram_write, a_ram_clken;

    logic        b_m0_waitrequest, b_m0_readdatavalid, b_m1_waitrequest, b_m1_readdatavalid;
    logic [31:0] b_m0_readdata, b_m1_readdata, b_ram_writedata, b_ram_readdata;
    logic [9:0]  b_ram_address;
    logic [3:0]  b_ram_byteenable;
    logic        b_ram_chipselect, b_ram_write, b_ram_clken;

    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:1023];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    clock_ram_arbiter #(.ADDR_W(10), .DATA_W(32), .BURST_MAX(2)) dut_a (
        .clk(clk), .reset(reset), .hold(hold),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(a_m0_waitrequest),
        .m0_readdatavalid(a_m0_readdatavalid), .m0_readdata(a_m0_readdata),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(a_m1_waitrequest),
        .m1_readdatavalid(a_m1_readdatavalid), .m1_readdata(a_m1_readdata),
        .ram_address(a_ram_address), .ram_byteenable(a_ram_byteenable),
        .ram_chipselect(a_ram_chipselect), .ram_write(a_ram_write),
        .ram_writedata(a_ram_writedata), .ram_clken(a_ram_clken), .ram_readdata(a_ram_readdata)
    );

    clock_ram_arbiter #(.ADDR_W(10), .DATA_W(32), .BURST_MAX(1)) dut_b (
        .clk(clk), .reset(reset), .hold(hold),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(b_m0_waitrequest),
        .m0_readdatavalid(b_m0_readdatavalid), .m0_readdata(b_m0_readdata),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(b_m1_waitrequest),
        .m1_readdatavalid(b_m1_readdatavalid), .m1_readdata(b_m1_readdata),
        .ram_address(b_ram_address), .ram_byteenable(b_ram_byteenable),
        .ram_chipselect(b_ram_chipselect), .ram_write(b_ram_write),
        .ram_writedata(b_ram_writedata), .ram_clken(b_ram_clken), .ram_readdata(b_ram_readdata)
    );

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 32'hA000_0000 | 32'(i);
            mem_b[i] = 32'hA000_0000 | 32'(i);
        end
    end

    always @(posedge clk) begin
        if (a_ram_chipselect && a_ram_clken) begin
            if (a_ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (a_ram_byteenable[b]) mem_a[a_ram_address][8*b +: 8] <= a_ram_writedata[8*b +: 8];
            end else begin
                a_ram_readdata <= mem_a[a_ram_address];
            end
        end
    end

    always @(posedge clk) begin
        if (b_ram_chipselect && b_ram_clken) begin
            if (b_ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (b_ram_byteenable[b]) mem_b[b_ram_address][8*b +: 8] <= b_ram_writedata[8*b +: 8];
            end else begin
                b_ram_readdata <= mem_b[b_ram_address];
            end
        end
    end

    task automatic m0_set(input logic rd, input logic wr, input logic [9:0] a,
                          input logic [3:0] be, input logic [31:0] d);
        m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
    endtask

    task automatic m1_set(input logic rd, input logic wr, input logic [9:0] a,
                          input logic [3:0] be, input logic [31:0] d);
        m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; hold = 1'b0;
        m0_set(0, 0, 10'h0, 4'h0, 32'h0);
        m1_set(0, 0, 10'h0, 4'h0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (a_ram_chipselect !== 1'b0) begin errors++; $display("FAIL rst_cs: got %b expected 0", a_ram_chipselect); end
        checks++; if (a_ram_clken !== 1'b1) begin errors++; $display("FAIL rst_clken: got %b expected 1", a_ram_clken); end
        checks++; if (a_m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_rv0: got %b expected 0", a_m0_readdatavalid); end
        checks++; if (a_m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_rv1: got %b expected 0", a_m1_readdatavalid); end
        checks++; if (a_m0_waitrequest !== 1'b0) begin errors++; $display("FAIL rst_wait0: got %b expected 0", a_m0_waitrequest); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_write();
        @(negedge clk);
        m0_set(0, 1, 10'h010, 4'hF, 32'hDEADBEEF);
        #1;
        checks++; if (a_m0_waitrequest !== 1'b0) begin errors++; $display("FAIL sw_wait_wr: got %b expected 0", a_m0_waitrequest); end
        checks++; if (a_ram_write !== 1'b1) begin errors++; $display("FAIL sw_ram_write: got %b expected 1", a_ram_write); end
        checks++; if (a_ram_address !== 10'h010) begin errors++; $display("FAIL sw_ram_addr: got %h expected 010", a_ram_address); end
        checks++; if (a_ram_writedata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_ram_wdata: got %h expected deadbeef", a_ram_writedata); end
        @(negedge clk);
        m0_set(1, 0, 10'h010, 4'hF, 32'h0);
        #1;
        checks++; if (a_m0_waitrequest !== 1'b0) begin errors++; $display("FAIL sw_wait_rd: got %b expected 0", a_m0_waitrequest); end
        checks++; if (a_ram_write !== 1'b0) begin errors++; $display("FAIL sw_ram_read: got %b expected 0", a_ram_write); end
        @(negedge clk);
        m0_set(0, 0, 10'h0, 4'h0, 32'h0);
        #1;
        checks++; if (a_m0_readdatavalid !== 1'b1) begin errors++; $display("FAIL sw_rv0: got %b expected 1", a_m0_readdatavalid); end
        checks++; if (a_m0_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_rdata: got %h expected deadbeef", a_m0_readdata); end
        checks++; if (a_m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL sw_rv1: got %b expected 0", a_m1_readdatavalid); end
    endtask

    // BURST_MAX=2: both masters read every cycle from reset.
    task automatic test_contention();
        bit          g0 [6] = '{1, 1, 0, 0, 1, 1};
        logic [31:0] exp_d;
        do_reset();
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            if (i < 6) begin
                m0_set(1, 0, 10'h010, 4'hF, 32'h0);
                m1_set(1, 0, 10'h020, 4'hF, 32'h0);
            end else begin
                m0_set(0, 0, 10'h0, 4'h0, 32'h0);
                m1_set(0, 0, 10'h0, 4'h0, 32'h0);
            end
            #1;
            if (i < 6) begin
                checks++; if (a_m0_waitrequest !== !g0[i]) begin errors++; $display("FAIL ct_wait0[%0d]: got %b expected %b", i, a_m0_waitrequest, !g0[i]); end
                checks++; if (a_m1_waitrequest !== g0[i]) begin errors++; $display("FAIL ct_wait1[%0d]: got %b expected %b", i, a_m1_waitrequest, g0[i]); end
            end
            if (i > 0) begin
                exp_d = g0[i-1] ? 32'hDEADBEEF : 32'hA000_0020;
                checks++; if (a_m0_readdatavalid !== g0[i-1]) begin errors++; $display("FAIL ct_rv0[%0d]: got %b expected %b", i, a_m0_readdatavalid, g0[i-1]); end
                checks++; if (a_m1_readdatavalid !== !g0[i-1]) begin errors++; $display("FAIL ct_rv1[%0d]: got %b expected %b", i, a_m1_readdatavalid, !g0[i-1]); end
                checks++; if (a_m0_readdata !== exp_d) begin errors++; $display("FAIL ct_rdata[%0d]: got %h expected %h", i, a_m0_readdata, exp_d); end
            end
        end
    endtask

    // BURST_MAX=1 (dut_b): writes from both masters alternate, m0 first.
    task automatic test_alternation();
        bit          w0 [5] = '{0, 1, 0, 1, 0};
        bit          w1 [5] = '{1, 0, 1, 0, 0};
        logic [9:0]  ea [5] = '{10'h040, 10'h041, 10'h042, 10'h050, 10'h051};
        logic [31:0] ed [5] = '{32'h1000_0040, 32'h1000_0041, 32'h1000_0042, 32'h2000_0050, 32'h2000_0051};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            case (i)
                0: begin m0_set(0, 1, 10'h040, 4'hF, 32'h1000_0040); m1_set(0, 1, 10'h050, 4'hF, 32'h2000_0050); end
                1: begin m0_set(0, 1, 10'h041, 4'hF, 32'h1000_0041); end
                2: begin m1_set(0, 1, 10'h051, 4'hF, 32'h2000_0051); end
                3: begin m0_set(0, 1, 10'h042, 4'hF, 32'h1000_0042); end
                4: begin m1_set(0, 0, 10'h0, 4'h0, 32'h0); end
                default: begin m0_set(0, 0, 10'h0, 4'h0, 32'h0); end
            endcase
            #1;
            if (i < 5) begin
                checks++; if (b_m0_waitrequest !== w0[i]) begin errors++; $display("FAIL alt_wait0[%0d]: got %b expected %b", i, b_m0_waitrequest, w0[i]); end
                checks++; if (b_m1_waitrequest !== w1[i]) begin errors++; $display("FAIL alt_wait1[%0d]: got %b expected %b", i, b_m1_waitrequest, w1[i]); end
            end
        end
        for (int i = 0; i < 5; i++) begin
            checks++; if (mem_b[ea[i]] !== ed[i]) begin errors++; $display("FAIL alt_mem[%h]: got %h expected %h", ea[i], mem_b[ea[i]], ed[i]); end
        end
    endtask

    task automatic test_byte_enable();
        @(negedge clk);
        m1_set(0, 1, 10'h060, 4'hF, 32'hFFFFFFFF);
        #1;
        checks++; if (a_m1_waitrequest !== 1'b0) begin errors++; $display("FAIL be_wait_fill: got %b expected 0", a_m1_waitrequest); end
        @(negedge clk);
        m1_set(0, 1, 10'h060, 4'h5, 32'h11223344);
        #1;
        checks++; if (a_ram_byteenable !== 4'h5) begin errors++; $display("FAIL be_ram_be: got %h expected 5", a_ram_byteenable); end
        @(negedge clk);
        m1_set(1, 0, 10'h060, 4'hF, 32'h0);
        @(negedge clk);
        m1_set(0, 0, 10'h0, 4'h0, 32'h0);
        #1;
        checks++; if (a_m1_readdatavalid !== 1'b1) begin errors++; $display("FAIL be_rv1: got %b expected 1", a_m1_readdatavalid); end
        checks++; if (a_m1_readdata !== 32'hFF22FF44) begin errors++; $display("FAIL be_rdata: got %h expected ff22ff44", a_m1_readdata); end
        checks++; if (a_m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL be_rv0: got %b expected 0", a_m0_readdatavalid); end
    endtask

    task automatic test_read_write_both();
        @(negedge clk);
        m0_set(1, 1, 10'h070, 4'hF, 32'h5555AAAA);
        #1;
        checks++; if (a_ram_write !== 1'b1) begin errors++; $display("FAIL rw_ram_write: got %b expected 1", a_ram_write); end
        @(negedge clk);
        m0_set(1, 0, 10'h070, 4'hF, 32'h0);
        #1;
        checks++; if (a_m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL rw_no_rv: got %b expected 0", a_m0_readdatavalid); end
        @(negedge clk);
        m0_set(0, 0, 10'h0, 4'h0, 32'h0);
        #1;
        checks++; if (a_m0_readdatavalid !== 1'b1) begin errors++; $display("FAIL rw_rv: got %b expected 1", a_m0_readdatavalid); end
        checks++; if (a_m0_readdata !== 32'h5555AAAA) begin errors++; $display("FAIL rw_rdata: got %h expected 5555aaaa", a_m0_readdata); end
    endtask

    task automatic test_hold();
        do_reset();
        @(negedge clk);
        m0_set(1, 0, 10'h010, 4'hF, 32'h0);
        #1;
        checks++; if (a_m0_waitrequest !== 1'b0) begin errors++; $display("FAIL hold_pre_wait: got %b expected 0", a_m0_waitrequest); end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            hold = 1'b1;
            m1_set(1, 0, 10'h020, 4'hF, 32'h0);
            #1;
            checks++; if (a_ram_chipselect !== 1'b0) begin errors++; $display("FAIL hold_cs[%0d]: got %b expected 0", i, a_ram_chipselect); end
            checks++; if (a_m0_waitrequest !== 1'b1) begin errors++; $display("FAIL hold_wait0[%0d]: got %b expected 1", i, a_m0_waitrequest); end
            checks++; if (a_m1_waitrequest !== 1'b1) begin errors++; $display("FAIL hold_wait1[%0d]: got %b expected 1", i, a_m1_waitrequest); end
            checks++; if (a_m0_readdatavalid !== (i == 1)) begin errors++; $display("FAIL hold_rv0[%0d]: got %b expected %b", i, a_m0_readdatavalid, (i == 1)); end
        end
        @(negedge clk);
        hold = 1'b0;
        #1;
        checks++; if (a_ram_chipselect !== 1'b1) begin errors++; $display("FAIL hold_resume_cs: got %b expected 1", a_ram_chipselect); end
        checks++; if (a_m0_waitrequest !== 1'b0) begin errors++; $display("FAIL hold_resume_wait0: got %b expected 0", a_m0_waitrequest); end
        checks++; if (a_m1_waitrequest !== 1'b1) begin errors++; $display("FAIL hold_resume_wait1: got %b expected 1", a_m1_waitrequest); end
        @(negedge clk);
        m0_set(0, 0, 10'h0, 4'h0, 32'h0);
        m1_set(0, 0, 10'h0, 4'h0, 32'h0);
        #1;
        checks++; if (a_m0_readdatavalid !== 1'b1) begin errors++; $display("FAIL hold_resume_rv0: got %b expected 1", a_m0_readdatavalid); end
    endtask

    // m1 read accepted, then reset right after the accepting edge. Without the
    // reset m1 would keep the port on the next contention.
    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        m1_set(1, 0, 10'h020, 4'hF, 32'h0);
        #1;
        checks++; if (a_m1_waitrequest !== 1'b0) begin errors++; $display("FAIL rm_wait1: got %b expected 0", a_m1_waitrequest); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        m1_set(0, 0, 10'h0, 4'h0, 32'h0);
        #1;
        checks++; if (a_m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL rm_rv1: got %b expected 0", a_m1_readdatavalid); end
        checks++; if (a_m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL rm_rv0: got %b expected 0", a_m0_readdatavalid); end
        @(negedge clk);
        reset = 1'b0;
        m0_set(1, 0, 10'h010, 4'hF, 32'h0);
        m1_set(1, 0, 10'h020, 4'hF, 32'h0);
        #1;
        checks++; if (a_m0_waitrequest !== 1'b0) begin errors++; $display("FAIL rm_wait0_post: got %b expected 0", a_m0_waitrequest); end
        checks++; if (a_m1_waitrequest !== 1'b1) begin errors++; $display("FAIL rm_wait1_post: got %b expected 1", a_m1_waitrequest); end
        checks++; if (b_m0_waitrequest !== 1'b0) begin errors++; $display("FAIL rm_b_wait0_post: got %b expected 0", b_m0_waitrequest); end
        @(negedge clk);
        m0_set(0, 0, 10'h0, 4'h0, 32'h0);
        m1_set(0, 0, 10'h0, 4'h0, 32'h0);
        #1;
        checks++; if (a_m0_readdatavalid !== 1'b1) begin errors++; $display("FAIL rm_rv0_post: got %b expected 1", a_m0_readdatavalid); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_alternation();
        test_byte_enable();
        test_read_write_both();
        test_hold();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
